// File: rtl/psum_in_bus_ctrl.sv
// psum_in_bus_ctrl: walks a range of group IDs and streams psum buffer words onto the PE-array bus
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, abort       begin a pass (idle only) / cancel the current pass
//   cfg_*              pass configuration, captured on an accepted start
//   buf_data/valid     psum buffer head; buf_ready is the combinational pop strobe
//   pe_ready_vec       per-router ready flags
//   source_id          ID broadcast to routers (registered)
//   bus_data_out/valid bus word to routers (registered, 1-cycle after the pop)
//   busy, done         not idle / one-cycle end-of-pass pulse
module psum_in_bus_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int NUM_PE     = 12,
    parameter int CNT_WIDTH  = 10,
    localparam int PW        = $clog2(NUM_PE + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ID_WIDTH-1:0]   cfg_base_id,
    input  logic [CNT_WIDTH-1:0]  cfg_num_ids,
    input  logic [CNT_WIDTH-1:0]  cfg_words_per_id,
    input  logic [PW-1:0]         cfg_pe_per_id,
    input  logic [DATA_WIDTH-1:0] buf_data,
    input  logic                  buf_valid,
    output logic                  buf_ready,
    input  logic [NUM_PE-1:0]     pe_ready_vec,
    output logic [ID_WIDTH-1:0]   source_id,
    output logic [DATA_WIDTH-1:0] bus_data_out,
    output logic                  bus_data_valid,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SEND, NEXT, DONE} state_t;
    state_t               state, nxt;
    logic [ID_WIDTH-1:0]  base_id;
    logic [CNT_WIDTH-1:0] num_ids, words, id_cnt, word_cnt, id_inc, word_inc;
    logic [PW-1:0]        pe_need, pe_cnt;
    logic                 settled, pop, kill;
    always_comb begin
        pe_cnt = '0;
        for (int i = 0; i < NUM_PE; i++) pe_cnt = pe_cnt + PW'(pe_ready_vec[i]);
    end
    assign id_inc    = id_cnt + CNT_WIDTH'(1);
    assign word_inc  = word_cnt + CNT_WIDTH'(1);
    assign kill      = abort && state != IDLE;
    assign pop       = state == SEND && buf_valid && word_cnt < words && !abort;
    assign buf_ready = pop;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    // settled is low in the first WAIT cycle so routers get one cycle to see the new source_id
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? (cfg_num_ids == '0 ? DONE : ISSUE) : IDLE;
            ISSUE:   nxt = WAIT;
            WAIT:    nxt = settled && pe_cnt >= pe_need ? (words == '0 ? NEXT : SEND) : WAIT;
            SEND:    nxt = pop && word_inc == words ? NEXT : SEND;
            NEXT:    nxt = id_inc == num_ids ? DONE : ISSUE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (kill) nxt = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            base_id        <= '0;
            num_ids        <= '0;
            words          <= '0;
            pe_need        <= '0;
            id_cnt         <= '0;
            word_cnt       <= '0;
            settled        <= 1'b0;
            source_id      <= '0;
            bus_data_out   <= '0;
            bus_data_valid <= 1'b0;
        end else begin
            state          <= nxt;
            settled        <= state == WAIT;
            bus_data_valid <= pop;
            if (pop) begin
                bus_data_out <= buf_data;
                word_cnt     <= word_inc;
            end
            if (state == IDLE && start) begin
                base_id <= cfg_base_id;
                num_ids <= cfg_num_ids;
                words   <= cfg_words_per_id;
                pe_need <= cfg_pe_per_id;
                id_cnt  <= '0;
            end
            if (state == ISSUE) begin
                source_id <= base_id + ID_WIDTH'(id_cnt);
                word_cnt  <= '0;
            end
            if (state == NEXT) id_cnt <= id_inc;
        end
    end
endmodule
